// File: rtl/alu_issue.sv
// Single-issue front end for a MIPS-style ALU: decodes one request, drives the
// external ALU for one cycle, then holds the captured result until it is consumed.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [4:0]  alu_ctl,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a producer holds its payload stable while valid=1 and ready=0.

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        is_bne;
  logic        dec_legal;
  logic        dec_bne;
  logic [4:0]  dec_ctl;
  logic [31:0] dec_b;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'h0000, imm};
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);

  always_comb begin
    dec_legal = 1'b1;
    dec_bne   = 1'b0;
    dec_ctl   = 5'd0;
    dec_b     = rt_val;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24:        dec_ctl = 5'd0;
          6'h25:        dec_ctl = 5'd1;
          6'h20, 6'h21: dec_ctl = 5'd2;
          6'h22, 6'h23: dec_ctl = 5'd6;
          6'h2A:        dec_ctl = 5'd7;
          6'h27:        dec_ctl = 5'd8;
          6'h26:        dec_ctl = 5'd9;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec_ctl = 5'd2; dec_b = imm_sext; end
      6'h0A:        begin dec_ctl = 5'd7; dec_b = imm_sext; end
      6'h0C:        begin dec_ctl = 5'd0; dec_b = imm_zext; end
      6'h0D:        begin dec_ctl = 5'd1; dec_b = imm_zext; end
      6'h0E:        begin dec_ctl = 5'd9; dec_b = imm_zext; end
      6'h04:        dec_ctl = 5'd6;
      6'h05:        begin dec_ctl = 5'd6; dec_bne = 1'b1; end
      default:      dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      is_bne      <= 1'b0;
      alu_ctl     <= 5'd0;
      op_a        <= 32'h0;
      op_b        <= 32'h0;
      rsp_result  <= 32'h0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (dec_legal) begin
              alu_ctl <= dec_ctl;
              op_a    <= rs_val;
              op_b    <= dec_b;
              is_bne  <= dec_bne;
              state   <= EXEC;
            end else begin
              // Illegal requests never touch the ALU operands.
              rsp_result  <= 32'h0;
              rsp_zero    <= 1'b0;
              rsp_illegal <= 1'b1;
              state       <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_result  <= alu_result;
          // For bne, report "branch taken" rather than the raw equality flag.
          rsp_zero    <= is_bne ? ~alu_zero : alu_zero;
          rsp_illegal <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the operand side, instruction-level
// reference model for expected results, directed cases followed by random requests.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic [4:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  alu_issue dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  // external ALU seen by the block
  always_comb begin
    case (alu_ctl)
      5'd0:    alu_result = op_a & op_b;
      5'd1:    alu_result = op_a | op_b;
      5'd2:    alu_result = op_a + op_b;
      5'd6:    alu_result = op_a - op_b;
      5'd7:    alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      5'd8:    alu_result = ~(op_a | op_b);
      5'd9:    alu_result = op_a ^ op_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: what the instruction means, not how it is decoded.
  task automatic ref_model(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                           output logic legal, output logic [4:0] ctl, output logic [31:0] b,
                           output logic [31:0] res, output logic z);
    logic [31:0] se;
    logic [31:0] ze;
    se = {{16{im[15]}}, im};
    ze = {16'h0, im};
    legal = 1'b1; ctl = 5'd0; b = rt; res = 32'h0;
    if (op == 6'h00) begin
      case (fn)
        6'h24:        begin ctl = 5'd0; res = rs & rt; end
        6'h25:        begin ctl = 5'd1; res = rs | rt; end
        6'h20, 6'h21: begin ctl = 5'd2; res = rs + rt; end
        6'h22, 6'h23: begin ctl = 5'd6; res = rs - rt; end
        6'h2A:        begin ctl = 5'd7; res = {31'h0, $signed(rs) < $signed(rt)}; end
        6'h27:        begin ctl = 5'd8; res = ~(rs | rt); end
        6'h26:        begin ctl = 5'd9; res = rs ^ rt; end
        default:      legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin ctl = 5'd2; b = se; res = rs + se; end
        6'h0A:        begin ctl = 5'd7; b = se; res = {31'h0, $signed(rs) < $signed(se)}; end
        6'h0C:        begin ctl = 5'd0; b = ze; res = rs & ze; end
        6'h0D:        begin ctl = 5'd1; b = ze; res = rs | ze; end
        6'h0E:        begin ctl = 5'd9; b = ze; res = rs ^ ze; end
        6'h04, 6'h05: begin ctl = 5'd6; res = rs - rt; end
        default:      legal = 1'b0;
      endcase
    end
    if (!legal) z = 1'b0;
    else if (op == 6'h04) z = (rs == rt);
    else if (op == 6'h05) z = (rs != rt);
    else z = (res == 32'h0);
  endtask

  // driver: issue one request, follow it to completion with 'stall' cycles of back-pressure
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [15:0] im, input int stall);
    logic        legal;
    logic        z;
    logic [4:0]  ctl;
    logic [31:0] b;
    logic [31:0] res;
    logic [33:0] e;
    ref_model(op, fn, rs, rt, im, legal, ctl, b, res, z);
    if (legal) exp_q.push_back({1'b0, z, res});
    else exp_q.push_back({1'b1, 1'b0, 32'h0});
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom);
    rs_val = $urandom; rt_val = $urandom; imm = 16'($urandom);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (legal) begin
      chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
      chk("alu_ctl", 32'(alu_ctl), 32'(ctl));
      chk("op_a", op_a, rs);
      chk("op_b", op_b, b);
      @(negedge clk);
      chk("alu_ctl_hold", 32'(alu_ctl), 32'(ctl));
      chk("op_b_hold", op_b, b);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    e = exp_q.pop_front();
    chk("rsp_result", rsp_result, e[31:0]);
    chk("rsp_zero", 32'(rsp_zero), 32'(e[32]));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(e[33]));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, e[31:0]);
      chk("stall_zero", 32'(rsp_zero), 32'(e[32]));
      chk("stall_illegal", 32'(rsp_illegal), 32'(e[33]));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    chk("req_ready_hs", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  logic [5:0] r_ops [10] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h00};
  logic [5:0] r_fns [9]  = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27, 6'h26};

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("reset_op_a", op_a, 32'h0);
    chk("reset_op_b", op_b, 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // directed cases
    send(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0);               // add -> 12
    send(6'h08, 6'h00, 32'd3, 32'd0, 16'hFFFF, 0);            // addi -1 -> 2
    send(6'h0C, 6'h00, 32'h1234_5678, 32'd0, 16'h8000, 0);   // andi zero-extended
    send(6'h04, 6'h00, 32'd9, 32'd9, 16'h0, 0);               // beq taken
    send(6'h05, 6'h00, 32'd9, 32'd9, 16'h0, 0);               // bne not taken
    send(6'h05, 6'h00, 32'd1, 32'd2, 16'h0, 0);               // bne taken
    send(6'h00, 6'h18, 32'd4, 32'd4, 16'h0, 0);               // illegal funct
    send(6'h23, 6'h00, 32'd4, 32'd4, 16'h0, 2);               // illegal opcode (lw)
    send(6'h00, 6'h22, 32'd10, 32'd10, 16'h0, 5);             // sub under back-pressure
    send(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 1);       // slt signed
    send(6'h0A, 6'h00, 32'd5, 32'd0, 16'h8000, 0);            // slti vs negative imm

    // random requests
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [5:0] op;
      logic [5:0] fn;
      logic [31:0] rs;
      logic [31:0] rt;
      k  = $urandom_range(0, 9);
      op = r_ops[k];
      fn = r_fns[$urandom_range(0, 8)];
      if (k == 9) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      send(op, fn, rs, rt, 16'($urandom), $urandom_range(0, 3));
    end

    // reset during EXEC aborts the xor
    chk("abort_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; opcode = 6'h00; funct = 6'h26; rs_val = 32'hF0F0; rt_val = 32'h0FF0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_exec", 32'(alu_ctl), 32'd9);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("abort_op_a", op_a, 32'h0);
    chk("abort_op_b", op_b, 32'h0);
    chk("abort_rsp_result", rsp_result, 32'h0);
    chk("abort_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("abort_rsp_illegal", 32'(rsp_illegal), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_ready_after", 32'(req_ready), 32'd1);
    end

    // reset during RESP discards a pending illegal response
    req_valid = 1'b1; opcode = 6'h3F; funct = 6'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_abort_valid_pre", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("resp_abort_valid", 32'(rsp_valid), 32'd0);
    chk("resp_abort_illegal", 32'(rsp_illegal), 32'd0);
    @(negedge clk);
    chk("resp_abort_ready", 32'(req_ready), 32'd1);
    chk("resp_abort_no_rsp", 32'(rsp_valid), 32'd0);

    send(6'h0D, 6'h00, 32'h0000_00F0, 32'd0, 16'h000F, 0);   // ori after aborts

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset.
REQ-002 Port list, one per line (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- opcode  in  6  MIPS instruction opcode.
- funct  in  6  MIPS funct field; used only when opcode==0.
- rs_val  in  32  rs register value.
- rt_val  in  32  rt register value.
- imm  in  16  instruction immediate.
- alu_ctl  out  5  ALU operation code to the ALU.
- op_a  out  32  ALU operand A.
- op_b  out  32  ALU operand B.
- alu_result  in  32  ALU combinational result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_illegal  out  1  request was not a supported instruction.

Function
REQ-003 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready.
REQ-005 On acceptance, the block SHALL register alu_ctl, op_a and op_b per REQ-006/007 and go to EXEC; an illegal request goes directly to RESP with rsp_result=0, rsp_zero=0, rsp_illegal=1.
REQ-006 R-type (opcode 0x00): op_a=rs_val, op_b=rt_val; funct 0x24->0, 0x25->1, 0x20->2, 0x21->2, 0x22->6, 0x23->6, 0x2A->7, 0x27->8, 0x26->9; any other funct is illegal.
REQ-007 I-type: op_a=rs_val; 0x08 addi->2 and 0x09 addiu->2 with op_b=sign-extended imm; 0x0A slti->7 with sign-extended imm; 0x0C andi->0, 0x0D ori->1, 0x0E xori->9 with zero-extended imm; 0x04 beq and 0x05 bne->6 with op_b=rt_val; any other opcode is illegal.
REQ-008 In EXEC (exactly one cycle), alu_ctl/op_a/op_b SHALL be held stable; at the end of EXEC rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_illegal<=0, and state<=RESP.
REQ-009 For bne, rsp_zero SHALL be the inverse of alu_zero, so that rsp_zero=1 means "branch taken" for both beq and bne.
REQ-010 rsp_valid SHALL be 1 exactly in RESP; rsp_result, rsp_zero and rsp_illegal SHALL hold constant while rsp_valid=1 and rsp_ready=0.
REQ-011 On rsp_valid&&rsp_ready, the FSM SHALL return to IDLE; no new request is accepted in that same cycle (req_ready rises the following cycle).
REQ-012 Latency for a legal request SHALL be 2 cycles from the acceptance edge to rsp_valid=1, and 1 cycle for an illegal request; throughput SHALL be at most one request per 3 cycles.
REQ-013 Outside EXEC, alu_ctl, op_a and op_b SHALL retain their last registered values; inputs opcode/funct/rs_val/rt_val/imm are ignored outside the acceptance edge.

Reset
REQ-014 With reset=1 at a rising edge, the state SHALL become IDLE and alu_ctl=0, op_a=0, op_b=0, rsp_result=0, rsp_zero=0, rsp_illegal=0; reset has priority over every other event.
REQ-015 Reset asserted in EXEC or RESP SHALL abort the operation; the pending response is discarded and is never presented.
REQ-016 req_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset is released.

Verification
REQ-017 R-type add: opcode=0x00, funct=0x20, rs=5, rt=7 -> alu_ctl=2, rsp_valid 2 cycles after acceptance, rsp_result=12, rsp_zero=0.
REQ-018 I-type addi with negative immediate: opcode=0x08, rs=3, imm=0xFFFF -> op_b=0xFFFFFFFF, rsp_result=2; andi with imm=0x8000 -> op_b=0x00008000.
REQ-019 Branches: beq with rs=rt=9 -> rsp_zero=1; bne with rs=rt=9 -> rsp_zero=0; bne with rs=1, rt=2 -> rsp_zero=1.
REQ-020 Illegal: opcode=0x00, funct=0x18 -> rsp_valid 1 cycle after acceptance, rsp_illegal=1, rsp_result=0, no EXEC cycle.
REQ-021 Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; then rsp_ready=1 -> IDLE next cycle and req_ready=1 one cycle later.
REQ-022 Reset in EXEC: accept xor, assert reset during EXEC -> rsp_valid never asserts, all outputs zero, req_ready=1 after reset is released.
